// File: rtl/imem_loader.sv
// Boot loader: assembles a UART byte stream into little-endian words and writes them into instruction memory.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int                ADDR_W         = 14,
    parameter logic [ADDR_W-1:0] BASE_WADDR     = 'h2000,
    parameter int                MEM_WORDS      = 16384,
    parameter int                TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int          TMO_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [31:0] MAX_WORDS = 32'(MEM_WORDS - int'(BASE_WADDR));

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {ST_LEN, ST_DATA, ST_CSUM, ST_DONE, ST_ERR} state_t;
`else
    typedef enum logic [2:0] {ST_LEN, ST_DATA, ST_DONE, ST_ERR} state_t;
`endif

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic [31:0] rx_len;
    logic [31:0] rx_word;
    logic        active;
    logic        tmo_run;

    assign rx_len  = {rx_data, len_q[31:8]};
    assign rx_word = {rx_data, word_q[31:8]};

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        len_d          = len_q;
        word_d         = word_q;
        words_loaded_d = words_loaded_q;
        tmo_d          = tmo_q;
        we_d           = 1'b0;
        waddr_d        = waddr_q;
        wdata_d        = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d         = csum_q;
        active         = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
        // Only the very first length byte may be waited for indefinitely.
        tmo_run        = (state_q == ST_DATA) || (state_q == ST_CSUM) ||
                         ((state_q == ST_LEN) && (byte_cnt_q != 2'd0));
`else
        active         = (state_q == ST_LEN) || (state_q == ST_DATA);
        tmo_run        = (state_q == ST_DATA) ||
                         ((state_q == ST_LEN) && (byte_cnt_q != 2'd0));
`endif

        if (restart) begin
            state_d        = ST_LEN;
            byte_cnt_d     = 2'd0;
            len_d          = 32'd0;
            word_d         = 32'd0;
            words_loaded_d = '0;
            tmo_d          = '0;
            waddr_d        = BASE_WADDR;
            wdata_d        = 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d         = 8'd0;
`endif
        end else begin
            if (rx_valid && active) begin
                tmo_d = '0;
            end else if (tmo_run) begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 2)) begin
                    state_d = ST_ERR;
                end
            end

            case (state_q)
                ST_LEN: begin
                    if (rx_valid) begin
                        len_d      = rx_len;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            if (rx_len == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_d = ST_CSUM;
`else
                                state_d = ST_DONE;
`endif
                            end else if (rx_len > MAX_WORDS) begin
                                state_d = ST_ERR;
                            end else begin
                                state_d = ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        word_d     = rx_word;
                        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d     = csum_q ^ rx_data;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            we_d           = 1'b1;
                            waddr_d        = BASE_WADDR + words_loaded_q[ADDR_W-1:0];
                            wdata_d        = rx_word;
                            words_loaded_d = words_loaded_q + (ADDR_W+1)'(1);
                            if (words_loaded_d == len_q[ADDR_W:0]) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_d = ST_CSUM;
`else
                                state_d = ST_DONE;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (rx_valid) begin
                        state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_LEN;
            byte_cnt_q     <= 2'd0;
            len_q          <= 32'd0;
            word_q         <= 32'd0;
            words_loaded_q <= '0;
            tmo_q          <= '0;
            we_q           <= 1'b0;
            waddr_q        <= BASE_WADDR;
            wdata_q        <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q         <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            len_q          <= len_d;
            word_q         <= word_d;
            words_loaded_q <= words_loaded_d;
            tmo_q          <= tmo_d;
            we_q           <= we_d;
            waddr_q        <= waddr_d;
            wdata_q        <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_loaded_q;
    assign cpu_hold     = (state_q != ST_DONE);
    assign load_done    = (state_q == ST_DONE);
    assign load_error   = (state_q == ST_ERR);

endmodule
